// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the vector/stack sequencer.
package cpu_pkg;

  localparam logic [7:0] RESET_ADDR = 8'h00;
  localparam logic [7:0] INTR_ADDR  = 8'h01;
  localparam logic [7:0] SP_INIT    = 8'hFF;
  localparam int         FLAG_W     = 4;

  typedef enum logic [3:0] {
    IDLE,
    RV_REQ,
    RV_LOAD,
    IP_PC,
    IP_FL,
    IV_REQ,
    IV_LOAD,
    RT_FL,
    RT_PC,
    RT_LOAD
  } seq_state_e;

endpackage

// File: rtl/vector_stack_sequencer.sv
// Data-memory initiator for reset-vector fetch, interrupt entry (push PC and
// flags, fetch vector) and return-from-interrupt (pop flags and PC).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | core owns the memory port; arbitrate RESET_IN > irq > rti
// RV_REQ  | read reset vector
// RV_LOAD | load PC from reset vector, SP <= SP_INIT, enable interrupts
// IP_PC   | push return PC at sp_work
// IP_FL   | push flags at sp_work-1, SP <= sp_work-2
// IV_REQ  | read interrupt vector
// IV_LOAD | load PC from interrupt vector, ack, mask interrupts
// RT_FL   | read saved flags at sp_work+1
// RT_PC   | restore flags, read saved PC at sp_work+2
// RT_LOAD | load PC, SP <= sp_work+2, unmask interrupts
module vector_stack_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              RESET_IN,
  input  logic              INTR_IN,
  input  logic              rti_req,
  input  logic [7:0]        pc_current,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [7:0]        sp_in,
  input  logic [7:0]        mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              pc_load,
  output logic [7:0]        pc_value,
  output logic              sp_write,
  output logic [7:0]        sp_value,
  output logic              flags_write,
  output logic [FLAG_W-1:0] flags_value,
  output logic              busy,
  output logic              intr_ack
);

  seq_state_e state_q, state_d;
  logic       ie_q, ie_d;
  logic       pending_q, pending_d;
  logic [7:0] sp_work_q, sp_work_d;

  // State register with synchronous reset into the reset-vector fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RV_REQ;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      sp_work_q <= SP_INIT;
    end else begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      sp_work_q <= sp_work_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d     = state_q;
    ie_d        = ie_q;
    pending_d   = pending_q | INTR_IN;
    sp_work_d   = sp_work_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = 8'h00;
    mem_wdata   = 8'h00;
    pc_load     = 1'b0;
    pc_value    = 8'h00;
    sp_write    = 1'b0;
    sp_value    = 8'h00;
    flags_write = 1'b0;
    flags_value = '0;
    busy        = 1'b1;
    intr_ack    = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (RESET_IN) begin
          state_d = RV_REQ;
        end else if (pending_q && ie_q) begin
          sp_work_d = sp_in;
          state_d   = IP_PC;
        end else if (rti_req) begin
          sp_work_d = sp_in;
          state_d   = RT_FL;
        end
      end
      RV_REQ: begin
        mem_read = 1'b1;
        mem_addr = RESET_ADDR;
        state_d  = RV_LOAD;
      end
      RV_LOAD: begin
        pc_load   = 1'b1;
        pc_value  = mem_rdata;
        sp_write  = 1'b1;
        sp_value  = SP_INIT;
        ie_d      = 1'b1;
        // A request arriving in this very cycle is still remembered.
        pending_d = INTR_IN;
        state_d   = IDLE;
      end
      IP_PC: begin
        mem_write = 1'b1;
        mem_addr  = sp_work_q;
        mem_wdata = pc_current;
        state_d   = IP_FL;
      end
      IP_FL: begin
        mem_write = 1'b1;
        mem_addr  = sp_work_q - 8'd1;
        mem_wdata = 8'(flags_in);
        sp_write  = 1'b1;
        sp_value  = sp_work_q - 8'd2;
        state_d   = IV_REQ;
      end
      IV_REQ: begin
        mem_read = 1'b1;
        mem_addr = INTR_ADDR;
        state_d  = IV_LOAD;
      end
      IV_LOAD: begin
        pc_load   = 1'b1;
        pc_value  = mem_rdata;
        intr_ack  = 1'b1;
        ie_d      = 1'b0;
        pending_d = INTR_IN;
        state_d   = IDLE;
      end
      RT_FL: begin
        mem_read = 1'b1;
        mem_addr = sp_work_q + 8'd1;
        state_d  = RT_PC;
      end
      RT_PC: begin
        flags_write = 1'b1;
        flags_value = mem_rdata[FLAG_W-1:0];
        mem_read    = 1'b1;
        mem_addr    = sp_work_q + 8'd2;
        state_d     = RT_LOAD;
      end
      RT_LOAD: begin
        pc_load  = 1'b1;
        pc_value = mem_rdata;
        sp_write = 1'b1;
        sp_value = sp_work_q + 8'd2;
        ie_d     = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = RV_REQ;
      end
    endcase

    // Abort: drop whatever the current step would have done, including any
    // remaining push write, and restart from the reset vector.
    if (RESET_IN && (state_q != IDLE)) begin
      state_d     = RV_REQ;
      ie_d        = ie_q;
      pending_d   = pending_q | INTR_IN;
      sp_work_d   = sp_work_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = 8'h00;
      mem_wdata   = 8'h00;
      pc_load     = 1'b0;
      pc_value    = 8'h00;
      sp_write    = 1'b0;
      sp_value    = 8'h00;
      flags_write = 1'b0;
      flags_value = '0;
      intr_ack    = 1'b0;
    end

    if (rst) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = 8'h00;
      mem_wdata   = 8'h00;
      pc_load     = 1'b0;
      pc_value    = 8'h00;
      sp_write    = 1'b0;
      sp_value    = 8'h00;
      flags_write = 1'b0;
      flags_value = '0;
      intr_ack    = 1'b0;
      busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_stack_sequencer.sv
// Bench for vector_stack_sequencer: synchronous memory model, scenario tasks
// and an abstract stack model (ref_mem) of what memory should contain.
module tb_vector_stack_sequencer;
  import cpu_pkg::*;

  logic              clk;
  logic              rst;
  logic              reset_in;
  logic              intr_in;
  logic              rti_req;
  logic [7:0]        pc_cur;
  logic [FLAG_W-1:0] flags_cur;
  logic [7:0]        sp_cur;
  logic [7:0]        mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [7:0]        mem_addr;
  logic [7:0]        mem_wdata;
  logic              pc_load;
  logic [7:0]        pc_value;
  logic              sp_write;
  logic [7:0]        sp_value;
  logic              flags_write;
  logic [FLAG_W-1:0] flags_value;
  logic              busy;
  logic              intr_ack;

  logic              pl_en;
  logic [7:0]        pl_addr;
  logic [7:0]        pl_data;
  logic [7:0]        mem [256];
  logic [7:0]        ref_mem [256];

  int checks;
  int errors;
  int cyc;

  logic [7:0]        wr_a[$];
  logic [7:0]        wr_d[$];
  logic [7:0]        rd_a[$];
  int                busy_n, pc_n, sp_n, fl_n, ack_n, both_n, ack_cyc, first_busy;
  logic [7:0]        pc_v, sp_v;
  logic [FLAG_W-1:0] fl_v;

  vector_stack_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .RESET_IN   (reset_in),
    .INTR_IN    (intr_in),
    .rti_req    (rti_req),
    .pc_current (pc_cur),
    .flags_in   (flags_cur),
    .sp_in      (sp_cur),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .pc_load    (pc_load),
    .pc_value   (pc_value),
    .sp_write   (sp_write),
    .sp_value   (sp_value),
    .flags_write(flags_write),
    .flags_value(flags_value),
    .busy       (busy),
    .intr_ack   (intr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    busy_n = 0; pc_n = 0; sp_n = 0; fl_n = 0; ack_n = 0; both_n = 0;
    ack_cyc = -1; first_busy = -1;
    pc_v = 8'h00; sp_v = 8'h00; fl_v = '0;
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (mem_write) begin wr_a.push_back(mem_addr); wr_d.push_back(mem_wdata); end
    if (mem_read) rd_a.push_back(mem_addr);
    if (mem_read && mem_write) both_n++;
    if (busy) begin busy_n++; if (first_busy < 0) first_busy = cyc; end
    if (pc_load) begin pc_n++; pc_v = pc_value; end
    if (sp_write) begin sp_n++; sp_v = sp_value; end
    if (flags_write) begin fl_n++; fl_v = flags_value; end
    if (intr_ack) begin ack_n++; ack_cyc = cyc; end
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    preload(RESET_ADDR, 8'h00);
    preload(INTR_ADDR, 8'h50);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || pc_load !== 1'b0 ||
        sp_write !== 1'b0 || intr_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: busy=%b rd=%b wr=%b pcl=%b spw=%b ack=%b want busy=1 rest=0",
               busy, mem_read, mem_write, pc_load, sp_write, intr_ack);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    repeat (4) cycle();
    checks++;
    if (rd_a.size() != 1 || rd_a[0] !== RESET_ADDR) begin
      errors++;
      $display("FAIL rv_read: reads=%0d addr=%h want 1 read at %h", rd_a.size(), rd_a[0], RESET_ADDR);
    end
    checks++;
    if (pc_n != 1 || pc_v !== ref_mem[RESET_ADDR]) begin
      errors++;
      $display("FAIL rv_pc: loads=%0d pc=%h want 1 load of %h", pc_n, pc_v, ref_mem[RESET_ADDR]);
    end
    checks++;
    if (sp_n != 1 || sp_v !== 8'hFF) begin
      errors++;
      $display("FAIL rv_sp: writes=%0d sp=%h want 1 write of ff", sp_n, sp_v);
    end
    checks++;
    if (busy_n != 2 || wr_a.size() != 0) begin
      errors++;
      $display("FAIL rv_busy: busy_cycles=%0d writes=%0d want 2 and 0", busy_n, wr_a.size());
    end
  endtask

  task automatic test_reset_in();
    ref_mem[RESET_ADDR] = ref_mem[RESET_ADDR];
    reset_in = 1'b1;
    clear_log();
    cycle();
    reset_in = 1'b0;
    repeat (4) cycle();
    checks++;
    if (pc_n != 1 || pc_v !== ref_mem[RESET_ADDR] || sp_n != 1 || sp_v !== SP_INIT || busy_n != 2) begin
      errors++;
      $display("FAIL reset_in: loads=%0d pc=%h sp_writes=%0d sp=%h busy=%0d want 1 %h 1 ff 2",
               pc_n, pc_v, sp_n, sp_v, busy_n, ref_mem[RESET_ADDR]);
    end
  endtask

  task automatic test_intr(input string tag, input logic [7:0] pc,
                           input logic [FLAG_W-1:0] fl, input logic [7:0] sp);
    logic [7:0] a1, fz, exp_sp, exp_vec;
    a1 = sp - 8'd1;
    fz = 8'(fl);
    exp_sp = sp - 8'd2;
    ref_mem[sp] = pc;
    ref_mem[a1] = fz;
    exp_vec = ref_mem[INTR_ADDR];
    pc_cur = pc; flags_cur = fl; sp_cur = sp;
    intr_in = 1'b1;
    clear_log();
    cycle();
    intr_in = 1'b0;
    repeat (7) cycle();
    checks++;
    if (wr_a.size() != 2 || wr_a[0] !== sp || wr_d[0] !== pc || wr_a[1] !== a1 || wr_d[1] !== fz) begin
      errors++;
      $display("FAIL %s push: n=%0d got %h:%h %h:%h want %h:%h %h:%h", tag, wr_a.size(),
               wr_a[0], wr_d[0], wr_a[1], wr_d[1], sp, pc, a1, fz);
    end
    checks++;
    if (rd_a.size() != 1 || rd_a[0] !== INTR_ADDR || pc_n != 1 || pc_v !== exp_vec) begin
      errors++;
      $display("FAIL %s vector: reads=%0d addr=%h loads=%0d pc=%h want 1 %h 1 %h", tag,
               rd_a.size(), rd_a[0], pc_n, pc_v, INTR_ADDR, exp_vec);
    end
    checks++;
    if (sp_n != 1 || sp_v !== exp_sp) begin
      errors++;
      $display("FAIL %s sp: writes=%0d sp=%h want 1 %h", tag, sp_n, sp_v, exp_sp);
    end
    checks++;
    if (ack_n != 1 || ack_cyc - first_busy != 3 || busy_n != 4 || both_n != 0) begin
      errors++;
      $display("FAIL %s timing: acks=%0d ack_offset=%0d busy=%0d rd_wr_overlap=%0d want 1 3 4 0",
               tag, ack_n, ack_cyc - first_busy, busy_n, both_n);
    end
  endtask

  task automatic test_rti(input string tag, input logic [7:0] sp);
    logic [7:0]        a1, a2;
    logic [FLAG_W-1:0] exp_fl;
    logic [7:0]        exp_pc;
    a1 = sp + 8'd1;
    a2 = sp + 8'd2;
    exp_fl = ref_mem[a1][FLAG_W-1:0];
    exp_pc = ref_mem[a2];
    sp_cur = sp;
    rti_req = 1'b1;
    clear_log();
    cycle();
    rti_req = 1'b0;
    repeat (6) cycle();
    checks++;
    if (rd_a.size() != 2 || rd_a[0] !== a1 || rd_a[1] !== a2 || wr_a.size() != 0) begin
      errors++;
      $display("FAIL %s pop_reads: n=%0d got %h %h writes=%0d want %h %h 0", tag, rd_a.size(),
               rd_a[0], rd_a[1], wr_a.size(), a1, a2);
    end
    checks++;
    if (fl_n != 1 || fl_v !== exp_fl || pc_n != 1 || pc_v !== exp_pc || sp_n != 1 || sp_v !== a2) begin
      errors++;
      $display("FAIL %s restore: fl=%0d:%h pc=%0d:%h sp=%0d:%h want 1:%h 1:%h 1:%h", tag,
               fl_n, fl_v, pc_n, pc_v, sp_n, sp_v, exp_fl, exp_pc, a2);
    end
    checks++;
    if (busy_n != 3 || ack_n != 0 || both_n != 0) begin
      errors++;
      $display("FAIL %s rti_timing: busy=%0d acks=%0d overlap=%0d want 3 0 0", tag, busy_n, ack_n, both_n);
    end
  endtask

  task automatic test_pending_after_rti();
    logic [7:0]        s, a1, a2, ns, new_pc, fz, exp_vec;
    logic [FLAG_W-1:0] exp_fl, new_fl;
    // Handler is running with interrupts masked: a new request must wait.
    intr_in = 1'b1;
    clear_log();
    cycle();
    intr_in = 1'b0;
    repeat (5) cycle();
    checks++;
    if (busy_n != 0 || ack_n != 0) begin
      errors++;
      $display("FAIL masked_irq: busy=%0d acks=%0d want 0 0", busy_n, ack_n);
    end
    s  = 8'hFD;
    a1 = s + 8'd1;
    a2 = s + 8'd2;
    exp_fl = ref_mem[a1][FLAG_W-1:0];
    ns = a2;
    new_pc = 8'h77;
    new_fl = 4'h5;
    fz = 8'(new_fl);
    ref_mem[ns] = new_pc;
    ref_mem[ns - 8'd1] = fz;
    exp_vec = ref_mem[INTR_ADDR];
    sp_cur = s;
    rti_req = 1'b1;
    clear_log();
    cycle();
    rti_req = 1'b0;
    sp_cur = ns; pc_cur = new_pc; flags_cur = new_fl;
    repeat (12) cycle();
    checks++;
    if (busy_n != 7 || ack_n != 1 || ack_cyc - first_busy != 7) begin
      errors++;
      $display("FAIL pending_service: busy=%0d acks=%0d ack_offset=%0d want 7 1 7",
               busy_n, ack_n, ack_cyc - first_busy);
    end
    checks++;
    if (fl_n != 1 || fl_v !== exp_fl || wr_a.size() != 2 || wr_a[0] !== ns || wr_d[0] !== new_pc ||
        wr_d[1] !== fz || pc_v !== exp_vec) begin
      errors++;
      $display("FAIL pending_data: fl=%h writes=%0d %h:%h %h pc=%h want %h 2 %h:%h %h %h",
               fl_v, wr_a.size(), wr_a[0], wr_d[0], wr_d[1], pc_v, exp_fl, ns, new_pc, fz, exp_vec);
    end
  endtask

  task automatic test_abort();
    logic [7:0] sp;
    test_reset_in();
    sp = 8'($urandom_range(8'h10, 8'hF0));
    pc_cur = 8'($urandom); flags_cur = 4'($urandom); sp_cur = sp;
    ref_mem[sp] = pc_cur;
    intr_in = 1'b1;
    clear_log();
    cycle();
    intr_in = 1'b0;
    cycle();
    cycle();
    reset_in = 1'b1;
    cycle();
    checks++;
    if (sp_n != 0 || pc_n != 0 || fl_n != 0 || ack_n != 0) begin
      errors++;
      $display("FAIL abort_cycle: sp_w=%0d pc_l=%0d fl_w=%0d ack=%0d want all 0", sp_n, pc_n, fl_n, ack_n);
    end
    reset_in = 1'b0;
    repeat (6) cycle();
    checks++;
    if (wr_a.size() != 1 || wr_a[0] !== sp || wr_d[0] !== pc_cur) begin
      errors++;
      $display("FAIL abort_push: writes=%0d first=%h:%h want 1 %h:%h", wr_a.size(), wr_a[0], wr_d[0], sp, pc_cur);
    end
    checks++;
    if (pc_n != 1 || pc_v !== ref_mem[RESET_ADDR] || sp_n != 1 || sp_v !== SP_INIT || ack_n != 0) begin
      errors++;
      $display("FAIL abort_reload: pc=%0d:%h sp=%0d:%h acks=%0d want 1:%h 1:ff 0",
               pc_n, pc_v, sp_n, sp_v, ack_n, ref_mem[RESET_ADDR]);
    end
  endtask

  task automatic test_priority();
    logic [7:0] sp, fz;
    sp = 8'h80;
    pc_cur = 8'h3C; flags_cur = 4'h9; sp_cur = sp;
    fz = 8'(flags_cur);
    ref_mem[sp] = pc_cur;
    ref_mem[sp - 8'd1] = fz;
    intr_in = 1'b1;
    clear_log();
    cycle();
    rti_req = 1'b1;
    cycle();
    intr_in = 1'b0;
    cycle();
    rti_req = 1'b0;
    repeat (7) cycle();
    checks++;
    if (ack_n != 1 || fl_n != 0 || wr_a.size() != 2 || wr_a[0] !== sp || rd_a.size() != 1 ||
        rd_a[0] !== INTR_ADDR || pc_v !== ref_mem[INTR_ADDR]) begin
      errors++;
      $display("FAIL irq_over_rti: acks=%0d fl_w=%0d writes=%0d a=%h reads=%0d r=%h pc=%h want 1 0 2 %h 1 %h %h",
               ack_n, fl_n, wr_a.size(), wr_a[0], rd_a.size(), rd_a[0], pc_v, sp, INTR_ADDR,
               ref_mem[INTR_ADDR]);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; reset_in = 1'b0; intr_in = 1'b0; rti_req = 1'b0;
    pc_cur = 8'h00; flags_cur = '0; sp_cur = 8'hFF;
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    clear_log();
    @(posedge clk); #1;
    test_reset();
    test_intr("intr_basic", 8'h23, 4'hA, 8'hFF);
    test_rti("rti_basic", 8'hFD);
    test_intr("intr_handler", 8'h41, 4'h3, 8'hFF);
    test_pending_after_rti();
    test_abort();
    test_intr("intr_wrap", 8'h66, 4'hC, 8'h00);
    test_rti("rti_wrap", 8'hFE);
    test_priority();
    test_reset_in();
    for (int i = 0; i < 16; i++) begin
      logic [7:0]        rpc, rsp;
      logic [FLAG_W-1:0] rfl;
      rpc = 8'($urandom);
      rfl = 4'($urandom);
      rsp = 8'($urandom);
      test_intr("intr_rand", rpc, rfl, rsp);
      test_rti("rti_rand", rsp - 8'd2);
      checks++;
      if (pc_v !== rpc || fl_v !== rfl || sp_v !== rsp) begin
        errors++;
        $display("FAIL rand_roundtrip: pc=%h fl=%h sp=%h want %h %h %h", pc_v, fl_v, sp_v, rpc, rfl, rsp);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
